vga_console_writer: RTL and testbench

// Byte-stream terminal front end for the VGA character memory; it is the write-side producer for that memory.

---
 rtl/vga_console_writer.sv | 181 ++++++++++++++++++
 tb/tb_vga_console_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_writer.sv
// vga_console_writer: byte-stream terminal front end that turns a character
// stream into single-cycle writes on the VGA character-memory write port,
// keeping its own cursor and handling LF, CR, BS, FF and line wrap.
module vga_console_writer #(
  parameter int         COLS   = 71,
  parameter int         ROWS   = 30,
  parameter logic [2:0] CLR_FG = 3'd7,
  parameter logic [2:0] CLR_BG = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic [2:0]  in_fg,
  input  logic [2:0]  in_bg,
  output logic        in_ready,
  output logic        cm_sel,
  output logic        cm_we,
  output logic [31:0] cm_addr,
  output logic [31:0] cm_din,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col
);

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  curRow_q, curRow_d;
  logic [6:0]  curCol_q, curCol_d;
  logic [4:0]  scanRow_q, scanRow_d;
  logic [6:0]  scanCol_q, scanCol_d;
  logic        cmWe_q, cmWe_d;
  logic [31:0] cmAddr_q, cmAddr_d;
  logic [31:0] cmDin_q, cmDin_d;

  // Char-mem address of a cell: column in the upper field, row below it.
  function automatic logic [31:0] cellAddr(input logic [4:0] r, input logic [6:0] c);
    return {19'b0, c, r, 1'b0};
  endfunction

  // Char-mem data word: colours above the ASCII code.
  function automatic logic [31:0] cellData(input logic [2:0] bg, input logic [2:0] fg,
                                           input logic [7:0] ch);
    return {18'b0, bg, fg, ch};
  endfunction

  localparam logic [31:0] BLANK = {18'b0, CLR_BG, CLR_FG, 8'h20};

  // Row that the cursor moves to on a newline, wrapping at the bottom.
  logic [4:0] nextRow;
  assign nextRow = (curRow_q == ROW_MAX) ? 5'd0 : curRow_q + 5'd1;

  // Next-state logic: decide the cursor move and the write for this cycle.
  always_comb begin
    state_d   = state_q;
    curRow_d  = curRow_q;
    curCol_d  = curCol_q;
    scanRow_d = scanRow_q;
    scanCol_d = scanCol_q;
    cmWe_d    = 1'b0;
    cmAddr_d  = cmAddr_q;
    cmDin_d   = cmDin_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            cmWe_d   = 1'b1;
            cmAddr_d = cellAddr(curRow_q, curCol_q);
            cmDin_d  = cellData(in_bg, in_fg, in_data);
            if (curCol_q < COL_MAX) begin
              curCol_d = curCol_q + 7'd1;
            end else begin
              curRow_d  = nextRow;
              curCol_d  = 7'd0;
              scanRow_d = nextRow;
              scanCol_d = 7'd0;
              state_d   = CLR_ROW;
            end
          end else if (in_data == CH_LF) begin
            curRow_d  = nextRow;
            curCol_d  = 7'd0;
            scanRow_d = nextRow;
            scanCol_d = 7'd0;
            state_d   = CLR_ROW;
          end else if (in_data == CH_CR) begin
            curCol_d = 7'd0;
          end else if (in_data == CH_BS) begin
            if (curCol_q != 7'd0) begin
              curCol_d = curCol_q - 7'd1;
              cmWe_d   = 1'b1;
              cmAddr_d = cellAddr(curRow_q, curCol_q - 7'd1);
              cmDin_d  = BLANK;
            end
          end else if (in_data == CH_FF) begin
            curRow_d  = 5'd0;
            curCol_d  = 7'd0;
            scanRow_d = 5'd0;
            scanCol_d = 7'd0;
            state_d   = CLR_ALL;
          end
        end
      end

      CLR_ROW: begin
        cmWe_d   = 1'b1;
        cmAddr_d = cellAddr(scanRow_q, scanCol_q);
        cmDin_d  = BLANK;
        if (scanCol_q == COL_MAX) begin
          state_d = IDLE;
        end else begin
          scanCol_d = scanCol_q + 7'd1;
        end
      end

      CLR_ALL: begin
        cmWe_d   = 1'b1;
        cmAddr_d = cellAddr(scanRow_q, scanCol_q);
        cmDin_d  = BLANK;
        if (scanCol_q == COL_MAX) begin
          scanCol_d = 7'd0;
          if (scanRow_q == ROW_MAX) begin
            state_d = IDLE;
          end else begin
            scanRow_d = scanRow_q + 5'd1;
          end
        end else begin
          scanCol_d = scanCol_q + 7'd1;
        end
      end

      default: begin
        state_d = CLR_ALL;
      end
    endcase
  end

  // State and registered bus outputs; reset aborts any clear and restarts a full one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLR_ALL;
      curRow_q  <= 5'd0;
      curCol_q  <= 7'd0;
      scanRow_q <= 5'd0;
      scanCol_q <= 7'd0;
      cmWe_q    <= 1'b0;
      cmAddr_q  <= 32'd0;
      cmDin_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      curRow_q  <= curRow_d;
      curCol_q  <= curCol_d;
      scanRow_q <= scanRow_d;
      scanCol_q <= scanCol_d;
      cmWe_q    <= cmWe_d;
      cmAddr_q  <= cmAddr_d;
      cmDin_q   <= cmDin_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign cm_we    = cmWe_q;
  assign cm_sel   = cmWe_q;
  assign cm_addr  = cmAddr_q;
  assign cm_din   = cmDin_q;
  assign cur_row  = curRow_q;
  assign cur_col  = curCol_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Testbench for vga_console_writer: directed cases plus a random character
// stream, checked against a screen-level model of the expected writes.
module tb_vga_console_writer;

  localparam int NCOLS = 71;
  localparam int NROWS = 30;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [2:0]  in_fg = 3'd0;
  logic [2:0]  in_bg = 3'd0;
  logic        in_ready;
  logic        cm_sel;
  logic        cm_we;
  logic [31:0] cm_addr;
  logic [31:0] cm_din;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
  } wr_t;

  wr_t wrQ[$];
  int  mRow = 0;
  int  mCol = 0;

  vga_console_writer dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_fg    (in_fg),
    .in_bg    (in_bg),
    .in_ready (in_ready),
    .cm_sel   (cm_sel),
    .cm_we    (cm_we),
    .cm_addr  (cm_addr),
    .cm_din   (cm_din),
    .cur_row  (cur_row),
    .cur_col  (cur_col)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addrOf(input int r, input int c);
    return 32'(c * 64 + r * 2);
  endfunction

  function automatic logic [31:0] dinOf(input int bg, input int fg, input int ch);
    return 32'(bg * 2048 + fg * 256 + ch);
  endfunction

  task automatic pushWrite(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.din  = d;
    wrQ.push_back(w);
  endtask

  task automatic modelClearRow(input int r);
    for (int c = 0; c < NCOLS; c++) pushWrite(addrOf(r, c), dinOf(0, 7, 8'h20));
  endtask

  task automatic modelClearAll();
    mRow = 0;
    mCol = 0;
    for (int r = 0; r < NROWS; r++) modelClearRow(r);
  endtask

  task automatic modelNewline();
    mRow = (mRow + 1) % NROWS;
    mCol = 0;
    modelClearRow(mRow);
  endtask

  // Screen-level effect of one accepted character.
  task automatic modelChar(input int ch, input int fg, input int bg);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      pushWrite(addrOf(mRow, mCol), dinOf(bg, fg, ch));
      if (mCol < NCOLS - 1) mCol++;
      else modelNewline();
    end else if (ch == 8'h0A) begin
      modelNewline();
    end else if (ch == 8'h0D) begin
      mCol = 0;
    end else if (ch == 8'h08) begin
      if (mCol > 0) begin
        mCol--;
        pushWrite(addrOf(mRow, mCol), dinOf(0, 7, 8'h20));
      end
    end else if (ch == 8'h0C) begin
      modelClearAll();
    end
  endtask

  // Advance to the next falling edge and check any write on the bus.
  task automatic tick();
    wr_t w;
    @(negedge clock);
    if (cm_we) begin
      checkOutput("wr_sel", 32'(cm_sel), 32'd1);
      if (wrQ.size() == 0) begin
        checkOutput("unexp_wr", 32'(cm_we), 32'd0);
      end else begin
        w = wrQ.pop_front();
        checkOutput("wr_addr", cm_addr, w.addr);
        checkOutput("wr_din", cm_din, w.din);
      end
    end
  endtask

  // Offer one character; returns in the cycle after the transfer.
  task automatic applyStimulus(input logic [7:0] ch, input logic [2:0] fg, input logic [2:0] bg);
    int n = 0;
    while (!in_ready && n < 5000) begin
      in_valid = 1'b0;
      tick();
      n++;
    end
    if (!in_ready) begin
      checkOutput("rdy_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    in_data  = ch;
    in_fg    = fg;
    in_bg    = bg;
    modelChar(int'(ch), int'(fg), int'(bg));
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles with in_ready low, starting with the current one.
  task automatic waitReady(output int lowCycles);
    lowCycles = 0;
    while (!in_ready && lowCycles < 5000) begin
      lowCycles++;
      tick();
    end
    checkOutput("q_drain", 32'(wrQ.size()), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    wrQ.delete();
    modelClearAll();
    tick();
    checkOutput("rst_we", 32'(cm_we), 32'd0);
    checkOutput("rst_addr", cm_addr, 32'd0);
    checkOutput("rst_row", 32'(cur_row), 32'd0);
    checkOutput("rst_col", 32'(cur_col), 32'd0);
    reset = 1'b0;
  endtask

  task automatic checkCursor(input string tag);
    checkOutput({tag, "_row"}, 32'(cur_row), 32'(mRow));
    checkOutput({tag, "_col"}, 32'(cur_col), 32'(mCol));
  endtask

  initial begin
    int lowCycles;
    int ffLeft;
    int pick;
    logic [7:0] ch;

    // Power-on reset and full clear.
    doReset();
    waitReady(lowCycles);
    checkOutput("clr_all_len", 32'(lowCycles), 32'd2130);
    checkOutput("clr_all_last", cm_addr, 32'h11BA);
    checkOutput("clr_all_din", cm_din, 32'h720);
    checkCursor("clr_all_cur");

    // First character and a back-to-back second one.
    applyStimulus(8'h41, 3'd2, 3'd1);
    checkOutput("a_we", 32'(cm_we), 32'd1);
    checkOutput("a_addr", cm_addr, 32'h0);
    checkOutput("a_din", cm_din, 32'hA41);
    checkOutput("a_col", 32'(cur_col), 32'd1);
    applyStimulus(8'h42, 3'd5, 3'd3);
    checkOutput("b_addr", cm_addr, 32'h40);
    checkOutput("b_din", cm_din, 32'h1D42);

    // Carriage return, then a full line that wraps.
    applyStimulus(8'h0D, 3'd0, 3'd0);
    checkCursor("cr_cur");
    for (int i = 0; i < NCOLS; i++) applyStimulus(8'(8'h30 + (i % 40)), 3'd7, 3'd0);
    checkOutput("wrap_addr", cm_addr, 32'h1180);
    checkOutput("wrap_row", 32'(cur_row), 32'd1);
    checkOutput("wrap_col", 32'(cur_col), 32'd0);
    waitReady(lowCycles);
    checkOutput("wrap_len", 32'(lowCycles), 32'd71);
    checkOutput("wrap_last", cm_addr, 32'h1182);

    // Walk down to row 29 and wrap back to row 0.
    for (int i = 0; i < 28; i++) applyStimulus(8'h0A, 3'd0, 3'd0);
    waitReady(lowCycles);
    checkOutput("row29", 32'(cur_row), 32'd29);
    applyStimulus(8'h0A, 3'd0, 3'd0);
    checkCursor("lf_wrap_cur");
    waitReady(lowCycles);
    checkOutput("lf_len", 32'(lowCycles), 32'd71);
    checkOutput("lf_last", cm_addr, 32'h1180);

    // Backspace at column 0 and at column 5.
    applyStimulus(8'h08, 3'd0, 3'd0);
    checkOutput("bs0_we", 32'(cm_we), 32'd0);
    checkCursor("bs0_cur");
    for (int i = 0; i < 5; i++) applyStimulus(8'h61, 3'd4, 3'd2);
    applyStimulus(8'h08, 3'd1, 3'd1);
    checkOutput("bs5_we", 32'(cm_we), 32'd1);
    checkOutput("bs5_addr", cm_addr, 32'h100);
    checkOutput("bs5_din", cm_din, 32'h720);
    checkOutput("bs5_col", 32'(cur_col), 32'd4);

    // Reset on the 10th cycle of a row clear.
    applyStimulus(8'h0A, 3'd0, 3'd0);
    for (int i = 0; i < 9; i++) tick();
    doReset();
    waitReady(lowCycles);
    checkOutput("rst_clr_len", 32'(lowCycles), 32'd2130);
    checkCursor("rst_clr_cur");

    // Random character stream against the screen model.
    ffLeft = 2;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 60) ch = 8'($urandom_range(8'h20, 8'h7E));
      else if (pick < 68) ch = 8'h0A;
      else if (pick < 74) ch = 8'h0D;
      else if (pick < 84) ch = 8'h08;
      else if (pick < 86 && ffLeft > 0) begin
        ch = 8'h0C;
        ffLeft--;
      end else if (pick < 93) ch = 8'($urandom_range(8'h7F, 8'hFF));
      else ch = 8'($urandom_range(0, 7));
      applyStimulus(ch, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      checkCursor("rnd_cur");
      if ($urandom_range(0, 3) == 0) begin
        for (int g = $urandom_range(1, 3); g > 0; g--) tick();
      end
    end
    waitReady(lowCycles);
    checkCursor("final_cur");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
